// File: rtl/instr_register_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_register_pkg
// Purpose  : Shared types for the instruction register and its FIFO
//            controller: opcode/operand/address/instruction types, controller
//            state encoding and register depth.
// Revision : 1.0 - initial release
// ============================================================================
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    localparam int IR_DEPTH = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ctrl_state_t;

    // Pointer increment; the 5-bit width makes 31 -> 0 wrap implicit.
    function automatic address_t ptr_inc(input address_t p);
        return p + address_t'(1);
    endfunction

endpackage : instr_register_pkg
`default_nettype wire

// File: rtl/instr_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : instr_rr_arbiter
// Purpose  : Two-requester round-robin arbiter. On contention the requester
//            not granted last wins; a lone requester always wins.
// Ports    : clk, reset  - clock, synchronous active-high reset
//            req[1:0]    - request vector
//            en          - grant is actually taken this cycle
//            grant[1:0]  - one-hot candidate grant (zero when no request)
// Revision : 1.0 - initial release
// ============================================================================
module instr_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    // Index of the requester granted most recently. Resets to 1 so that
    // requester 0 wins the first contended cycle.
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase

        // History only advances when a grant is really consumed, so a
        // blocked cycle (full / draining) does not skip a requester.
        last_grant_d = last_grant_q;
        if (en && (|req)) begin
            last_grant_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule : instr_rr_arbiter
`default_nettype wire

// File: rtl/instr_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_reg_ctrl
// Purpose  : FIFO controller for a 32-entry external instruction register.
//            Two requesters write through a round-robin arbiter, a single
//            consumer reads in order. A drain command stops writes, lets
//            reads empty the register and reports completion with a pulse.
// Ports    : clk, reset                    - clock, sync active-high reset
//            req_valid/req_ready[1:0]      - per-requester handshake
//            req_opcode/req_op_a/req_op_b  - per-requester payload
//            drain / drain_done            - drain start / completion pulse
//            rd_valid/rd_ready/rd_instr    - consumer handshake and data
//            count, full, empty, almost_full - occupancy status
//            load_en, write_pointer, read_pointer, opcode, operand_a,
//            operand_b, instruction_word   - instruction register interface
// Config   : INSTR_REG_CTRL_STATS_EN adds saturating per-requester transfer
//            counters grant_cnt0 / grant_cnt1.
// Revision : 1.0 - initial release
// ============================================================================
module instr_reg_ctrl
    import instr_register_pkg::*;
#(
    parameter int AFULL_LVL = 28
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    input  opcode_t      req_opcode [2],
    input  operand_t     req_op_a   [2],
    input  operand_t     req_op_b   [2],
    output logic [1:0]   req_ready,
    input  logic         drain,
    output logic         drain_done,
    output logic         rd_valid,
    input  logic         rd_ready,
    output instruction_t rd_instr,
    output logic [5:0]   count,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         load_en,
    output address_t     write_pointer,
    output address_t     read_pointer,
    output opcode_t      opcode,
    output operand_t     operand_a,
    output operand_t     operand_b,
    input  instruction_t instruction_word
`ifdef INSTR_REG_CTRL_STATS_EN
    ,
    output logic [31:0]  grant_cnt0,
    output logic [31:0]  grant_cnt1
`endif
);

    ctrl_state_t state_q, state_d;
    address_t    wr_ptr_q, wr_ptr_d;
    address_t    rd_ptr_q, rd_ptr_d;
    logic [5:0]  count_q, count_d;

    logic [1:0]  grant;
    logic        accept_en;
    logic        wr_fire;
    logic        rd_fire;
    logic        gsel;

    // ------------------------------------------------------------------
    // Status, all decoded from the registered occupancy
    // ------------------------------------------------------------------
    assign count       = count_q;
    assign full        = (count_q == 6'(IR_DEPTH));
    assign empty       = (count_q == 6'd0);
    assign almost_full = (count_q >= 6'(AFULL_LVL));

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    // Full is taken from the registered count, so a read in the same cycle
    // does not open a slot for a write until the next cycle.
    assign accept_en = (state_q == RUN) && !full && !reset;

    instr_rr_arbiter u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (accept_en),
        .grant (grant)
    );

    assign req_ready     = grant & {2{accept_en}};
    assign wr_fire       = |(req_valid & req_ready);
    assign gsel          = grant[1];

    assign load_en       = wr_fire;
    assign write_pointer = wr_ptr_q;
    assign opcode        = req_opcode[gsel];
    assign operand_a     = req_op_a[gsel];
    assign operand_b     = req_op_b[gsel];

    // ------------------------------------------------------------------
    // Read side: a new entry only becomes visible once count_q includes it
    // ------------------------------------------------------------------
    assign rd_valid      = !empty && !reset;
    assign rd_fire       = rd_valid && rd_ready;
    assign read_pointer  = rd_ptr_q;
    assign rd_instr      = instruction_word;

    assign drain_done    = (state_q == DONE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 6'd1;
            2'b01:   count_d = count_q - 6'd1;
            default: count_d = count_q;
        endcase

        // Drain entered while already empty still spends one cycle in DRAIN.
        state_d = state_q;
        case (state_q)
            RUN:     if (drain) state_d = DRAIN;
            DRAIN:   if (empty) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef INSTR_REG_CTRL_STATS_EN
    // ------------------------------------------------------------------
    // Saturating per-requester transfer counters
    // ------------------------------------------------------------------
    logic [31:0] grant_cnt0_q, grant_cnt0_d;
    logic [31:0] grant_cnt1_q, grant_cnt1_d;

    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (req_valid[0] && req_ready[0] && (grant_cnt0_q != '1)) begin
            grant_cnt0_d = grant_cnt0_q + 32'd1;
        end
        if (req_valid[1] && req_ready[1] && (grant_cnt1_q != '1)) begin
            grant_cnt1_d = grant_cnt1_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule : instr_reg_ctrl
`default_nettype wire

// File: tb/tb_instr_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_reg_ctrl
// Purpose  : Self-checking bench for instr_reg_ctrl. A queue-based FIFO model
//            predicts every output each cycle; directed scenarios add literal
//            expectations for the key behaviours.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_reg_ctrl;
    import instr_register_pkg::*;

    localparam int AFULL = 28;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    opcode_t      req_opcode [2];
    operand_t     req_op_a   [2];
    operand_t     req_op_b   [2];
    logic [1:0]   req_ready;
    logic         drain;
    logic         drain_done;
    logic         rd_valid;
    logic         rd_ready;
    instruction_t rd_instr;
    logic [5:0]   count;
    logic         full, empty, almost_full;
    logic         load_en;
    address_t     write_pointer, read_pointer;
    opcode_t      opcode;
    operand_t     operand_a, operand_b;
    instruction_t instruction_word;
`ifdef INSTR_REG_CTRL_STATS_EN
    logic [31:0]  grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    instr_reg_ctrl #(.AFULL_LVL(AFULL)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_opcode       (req_opcode),
        .req_op_a         (req_op_a),
        .req_op_b         (req_op_b),
        .req_ready        (req_ready),
        .drain            (drain),
        .drain_done       (drain_done),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_instr         (rd_instr),
        .count            (count),
        .full             (full),
        .empty            (empty),
        .almost_full      (almost_full),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .instruction_word (instruction_word)
`ifdef INSTR_REG_CTRL_STATS_EN
        ,
        .grant_cnt0       (grant_cnt0),
        .grant_cnt1       (grant_cnt1)
`endif
    );

    // External instruction register storage
    instruction_t regfile [32];
    always @(posedge clk) begin
        if (load_en) regfile[write_pointer] <= '{opcode, operand_a, operand_b};
    end
    assign instruction_word = regfile[read_pointer];

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: FIFO contents as a queue, pointers as running
    // totals, controller phase as 0=accepting, 1=draining, 2=finished.
    // ------------------------------------------------------------------
    instruction_t mq[$];
    int           wr_total = 0;
    int           rd_total = 0;
    int           mode = 0;
    int           mode_next = 0;
    bit           last_g = 1'b1;
    bit           do_wr = 1'b0;
    bit           do_rd = 1'b0;
    int           g_sel = 0;
    instruction_t wr_item;

    always @(negedge clk) begin
        int sz;
        int g;
        logic [1:0] exp_ready;
        do_wr = 1'b0;
        do_rd = 1'b0;
        if (reset) begin
            chk("m_ready_rst", req_ready, 2'b00);
            chk("m_load_rst", load_en, 1'b0);
            mode_next = 0;
        end else begin
            sz = mq.size();
            chk("m_count", count, sz);
            chk("m_full", full, sz == 32);
            chk("m_empty", empty, sz == 0);
            chk("m_afull", almost_full, sz >= AFULL);
            chk("m_rd_valid", rd_valid, sz > 0);
            chk("m_drain_done", drain_done, mode == 2);
            chk("m_rd_ptr", read_pointer, rd_total % 32);
            chk("m_wr_ptr", write_pointer, wr_total % 32);
            if (sz > 0) chk("m_rd_instr", rd_instr, mq[0]);

            g = -1;
            if (mode == 0 && sz < 32) begin
                if (req_valid == 2'b11) g = last_g ? 0 : 1;
                else if (req_valid[0])  g = 0;
                else if (req_valid[1])  g = 1;
            end
            exp_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
            chk("m_req_ready", req_ready, exp_ready);
            chk("m_load_en", load_en, g >= 0);
            if (g >= 0) begin
                chk("m_opcode", opcode, req_opcode[g]);
                chk("m_op_a", operand_a, req_op_a[g]);
                chk("m_op_b", operand_b, req_op_b[g]);
                do_wr   = 1'b1;
                g_sel   = g;
                wr_item = '{req_opcode[g], req_op_a[g], req_op_b[g]};
            end
            do_rd = (sz > 0) && rd_ready;

            mode_next = mode;
            if (mode == 0 && drain)        mode_next = 1;
            else if (mode == 1 && sz == 0) mode_next = 2;
            else if (mode == 2)            mode_next = 0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            wr_total = 0;
            rd_total = 0;
            mode     = 0;
            last_g   = 1'b1;
        end else begin
            if (do_rd) begin
                void'(mq.pop_front());
                rd_total++;
            end
            if (do_wr) begin
                mq.push_back(wr_item);
                wr_total++;
                last_g = g_sel[0];
            end
            mode = mode_next;
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [1:0] exp_g [4];

    initial begin
        reset      = 1'b1;
        drain      = 1'b0;
        req_valid  = 2'b00;
        rd_ready   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_opcode[i] = ZERO;
            req_op_a[i]   = '0;
            req_op_b[i]   = '0;
        end
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_count", count, 6'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_afull", almost_full, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_drain_done", drain_done, 1'b0);
        tick();

        // Lone requester 0: ADD 5,3 three times
        do_reset();
        req_opcode[0] = ADD; req_op_a[0] = 5; req_op_b[0] = 3;
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s1_wr_ptr", write_pointer, i);
            chk("s1_load", load_en, 1'b1);
            tick();
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("s1_count", count, 6'd3);
        tick();
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s1_rd_opc", rd_instr.opc, ADD);
            chk("s1_rd_a", rd_instr.op_a, 5);
            chk("s1_rd_b", rd_instr.op_b, 3);
            tick();
        end
        rd_ready = 1'b0;

        // Contention: grants alternate 0,1,0,1
        do_reset();
        req_opcode[0] = SUB;  req_op_a[0] = 1; req_op_b[0] = 2;
        req_opcode[1] = MULT; req_op_a[1] = 7; req_op_b[1] = 8;
        req_valid = 2'b11;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s2_grant", req_ready, exp_g[i]);
            chk("s2_not_both", &req_ready, 1'b0);
            tick();
        end
        req_valid = 2'b00;

        // Fill to full, then read+write request at full
        do_reset();
        req_opcode[0] = PASSA;
        req_valid = 2'b01;
        for (int i = 0; i < 32; i++) begin
            req_op_a[0] = i;
            @(negedge clk);
            chk("s3_afull", almost_full, i >= 28);
            tick();
        end
        @(negedge clk);
        chk("s3_full", full, 1'b1);
        chk("s3_count32", count, 6'd32);
        chk("s3_ready_full", req_ready, 2'b00);
        tick();
        rd_ready = 1'b1;
        @(negedge clk);
        chk("s3_no_load", load_en, 1'b0);
        tick();
        rd_ready  = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("s3_count31", count, 6'd31);
        chk("s3_not_full", full, 1'b0);
        tick();

        // 34 writes with interleaved reads: pointer wrap and ordering
        do_reset();
        req_opcode[1] = PASSB;
        req_valid = 2'b10;
        for (int i = 0; i < 34; i++) begin
            req_op_a[1] = 100 + i;
            req_op_b[1] = i;
            rd_ready    = i[0];
            tick();
        end
        req_valid = 2'b00;
        rd_ready  = 1'b0;
        @(negedge clk);
        chk("s4_wr_wrap", write_pointer, 5'd2);
        chk("s4_count", count, 6'd17);
        tick();
        rd_ready = 1'b1;
        repeat (17) tick();
        rd_ready = 1'b0;
        @(negedge clk);
        chk("s4_rd_wrap", read_pointer, 5'd2);
        chk("s4_empty", empty, 1'b1);
        tick();

        // Drain with 5 entries; writes refused until back in RUN
        do_reset();
        req_opcode[0] = DIV;
        req_valid = 2'b01;
        repeat (5) tick();
        req_valid = 2'b00;
        drain = 1'b1;
        tick();
        drain     = 1'b0;
        rd_ready  = 1'b1;
        req_valid = 2'b01;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("s5_done", drain_done, k == 6);
            chk("s5_load", load_en, k == 7);
            if (k <= 5) chk("s5_count", count, 5 - k);
            tick();
        end
        req_valid = 2'b00;
        repeat (3) tick();
        rd_ready = 1'b0;

        // Drain while already empty: one DRAIN cycle then DONE
        do_reset();
        drain = 1'b1;
        tick();
        drain = 1'b0;
        @(negedge clk);
        chk("s6_drain_cyc", drain_done, 1'b0);
        tick();
        @(negedge clk);
        chk("s6_done", drain_done, 1'b1);
        tick();
        @(negedge clk);
        chk("s6_done_off", drain_done, 1'b0);
        tick();

        // Reset in the middle of a drain with 4 entries
        do_reset();
        req_opcode[0] = MOD;
        req_valid = 2'b01;
        repeat (4) tick();
        req_valid = 2'b00;
        drain = 1'b1;
        tick();
        drain = 1'b0;
        @(negedge clk);
        chk("s7_count4", count, 6'd4);
        tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = 2'b01;
        @(negedge clk);
        chk("s7_count0", count, 6'd0);
        chk("s7_empty", empty, 1'b1);
        chk("s7_run", req_ready, 2'b01);
        chk("s7_no_done", drain_done, 1'b0);
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s7_no_done_after", drain_done, 1'b0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instr_reg_ctrl
`default_nettype wire
